// File: rtl/di_i2c_init_seq_pkg.sv
// Shared definitions for the DI-to-I2C init sequencer: table entry layout,
// opcodes, transfer status and FSM state encoding.
package di_i2c_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 30;
    localparam int REG_HI  = 23;
    localparam int REG_LO  = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;
    localparam int CNT_HI  = 23;
    localparam int CNT_LO  = 0;

    localparam logic [15:0] STATUS_OK = 16'h0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_ACCEPT,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_GAP,
        ST_DELAY,
        ST_FINISH
    } state_t;

    // What the sequencer does once the inter-transaction gap has elapsed.
    typedef enum logic [1:0] {
        GAP_ADVANCE,
        GAP_RETRY,
        GAP_FINISH
    } gap_next_t;

endpackage

// File: rtl/di_i2c_init_seq_if.sv
// DI register-write bus between the init sequencer (master) and the DI-to-I2C
// glue (slave). A write is one di_write strobe inside a di_write_mode window;
// the slave drops di_write_rdy while busy and raises it with di_transfer_status valid.
interface di_i2c_init_seq_if;
    import di_i2c_pkg::*;

    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [7:0]  di_reg_datai;
    logic        di_write_mode;
    logic        di_write;
    logic        di_write_rdy;
    logic [15:0] di_transfer_status;
    state_t      dbg_state;

    modport master (
        output di_term_addr, di_reg_addr, di_reg_datai, di_write_mode, di_write, dbg_state,
        input  di_write_rdy, di_transfer_status
    );

    modport slave (
        input  di_term_addr, di_reg_addr, di_reg_datai, di_write_mode, di_write, dbg_state,
        output di_write_rdy, di_transfer_status
    );

endinterface

// File: rtl/di_i2c_init_delay.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module di_i2c_init_delay #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/di_i2c_init_seq.sv
// Walks a ROM command table and issues DI register writes with retry, delay and gap handling.
// Optional macro DI_I2C_INIT_SEQ_TIMEOUT_EN adds a WAIT_DONE watchdog and a sticky timeout output.
module di_i2c_init_seq
    import di_i2c_pkg::*;
#(
    parameter int ROM_AW      = 8,
    parameter int MAX_RETRIES = 3,
    parameter int GAP_CYCLES  = 2,
    parameter int ACCEPT_WAIT = 8
) (
    input  logic              ifclk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       term_addr,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    di_i2c_init_seq_if.master di,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_index
`ifdef DI_I2C_INIT_SEQ_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam logic [ROM_AW-1:0] LAST_INDEX = '1;
    localparam int ACC_W = $clog2(ACCEPT_WAIT + 1);

    state_t            state;
    gap_next_t         gap_next;
    logic [ROM_AW-1:0] index;
    logic [3:0]        retry;
    logic [ACC_W-1:0]  acc_cnt;
    logic [1:0]        op;
    logic              cnt_load;
    logic [23:0]       cnt_val;
    logic              cnt_zero;
    logic              attempt_ok;
    logic              unused_rom_bits;

    assign op              = rom_data[OP_HI:OP_LO];
    assign unused_rom_bits = ^rom_data[29:24];
    assign di.dbg_state    = state;

    // DELAY and GAP never overlap, so one counter serves both; it is loaded
    // in the cycle before the state that consumes it.
    assign cnt_load = ((state == ST_DECODE) && (op == OP_DELAY)) || (state == ST_CHECK);
    assign cnt_val  = (state == ST_CHECK) ? 24'(GAP_CYCLES - 1) : rom_data[CNT_HI:CNT_LO];

    di_i2c_init_delay #(.W(24)) u_delay (
        .clk      (ifclk),
        .rst      (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

`ifdef DI_I2C_INIT_SEQ_TIMEOUT_EN
    logic [19:0] wd_cnt;
    logic        wd_fail;
    assign attempt_ok = (di.di_transfer_status == STATUS_OK) && !wd_fail;
`else
    assign attempt_ok = (di.di_transfer_status == STATUS_OK);
`endif

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            gap_next         <= GAP_ADVANCE;
            index            <= '0;
            retry            <= '0;
            acc_cnt          <= '0;
            rom_addr         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            err_index        <= '0;
            di.di_term_addr  <= '0;
            di.di_reg_addr   <= '0;
            di.di_reg_datai  <= '0;
            di.di_write_mode <= 1'b0;
            di.di_write      <= 1'b0;
`ifdef DI_I2C_INIT_SEQ_TIMEOUT_EN
            wd_cnt           <= '0;
            wd_fail          <= 1'b0;
            timeout          <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        error           <= 1'b0;
                        err_index       <= '0;
                        index           <= '0;
                        rom_addr        <= '0;
                        busy            <= 1'b1;
                        di.di_term_addr <= term_addr;
`ifdef DI_I2C_INIT_SEQ_TIMEOUT_EN
                        timeout         <= 1'b0;
`endif
                        state           <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    case (op)
                        OP_WRITE: begin
                            di.di_reg_addr   <= {16'h0, rom_data[REG_HI:REG_LO]};
                            di.di_reg_datai  <= rom_data[DATA_HI:DATA_LO];
                            retry            <= '0;
                            di.di_write_mode <= 1'b1;
                            di.di_write      <= 1'b1;
                            state            <= ST_ISSUE;
                        end
                        OP_DELAY: state <= ST_DELAY;
                        OP_END: begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FINISH;
                        end
                        default: begin
                            error     <= 1'b1;
                            err_index <= index;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_FINISH;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    di.di_write <= 1'b0;
                    acc_cnt     <= '0;
`ifdef DI_I2C_INIT_SEQ_TIMEOUT_EN
                    wd_fail     <= 1'b0;
                    wd_cnt      <= '0;
`endif
                    state       <= ST_WAIT_ACCEPT;
                end
                // A terminal that never drops ready is treated as having finished.
                ST_WAIT_ACCEPT: begin
                    if (!di.di_write_rdy) begin
                        state <= ST_WAIT_DONE;
                    end else if (acc_cnt == ACC_W'(ACCEPT_WAIT - 1)) begin
                        state <= ST_CHECK;
                    end else begin
                        acc_cnt <= acc_cnt + ACC_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (di.di_write_rdy) begin
                        state <= ST_CHECK;
                    end
`ifdef DI_I2C_INIT_SEQ_TIMEOUT_EN
                    else if (wd_cnt == 20'hFFFFF) begin
                        wd_fail <= 1'b1;
                        timeout <= 1'b1;
                        state   <= ST_CHECK;
                    end else begin
                        wd_cnt <= wd_cnt + 20'd1;
                    end
`endif
                end
                ST_CHECK: begin
                    di.di_write_mode <= 1'b0;
                    state            <= ST_GAP;
                    if (attempt_ok) begin
                        gap_next <= GAP_ADVANCE;
                    end else if (retry < 4'(MAX_RETRIES)) begin
                        retry    <= retry + 4'd1;
                        gap_next <= GAP_RETRY;
                    end else begin
                        error     <= 1'b1;
                        err_index <= index;
                        gap_next  <= GAP_FINISH;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        case (gap_next)
                            GAP_RETRY: begin
                                di.di_write_mode <= 1'b1;
                                di.di_write      <= 1'b1;
                                state            <= ST_ISSUE;
                            end
                            GAP_FINISH: begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_FINISH;
                            end
                            default: begin
                                if (index == LAST_INDEX) begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= ST_FINISH;
                                end else begin
                                    index    <= index + ROM_AW'(1);
                                    rom_addr <= index + ROM_AW'(1);
                                    state    <= ST_FETCH;
                                end
                            end
                        endcase
                    end
                end
                ST_DELAY: begin
                    if (cnt_zero) begin
                        if (index == LAST_INDEX) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FINISH;
                        end else begin
                            index    <= index + ROM_AW'(1);
                            rom_addr <= index + ROM_AW'(1);
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/di_i2c_init_seq.md
Name: di_i2c_init_seq

Overview:
- Upstream DI-bus master for the DI-to-I2C glue block. On `start`, walks a command table held in an external synchronous ROM and issues DI register writes to one I2C terminal.
- Used to configure sensors/PMICs after power-up without host software.
- Waits for each write to complete, checks transfer status, retries on NACK, supports inserted delays, and reports done/error.

Parameters:
- ROM_AW, 8, ROM address width; table depth 2**ROM_AW entries.
- MAX_RETRIES, 3, re-issues per entry after a nonzero status before erroring (0..15).
- GAP_CYCLES, 2, cycles `di_write_mode` is held low between transactions (min 1).
- ACCEPT_WAIT, 8, max cycles to see `di_write_rdy` fall after a write pulse.

Ports:
- ifclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins sequence at index 0
- term_addr  in  16  DI terminal address of the target I2C device
- rom_addr  out  ROM_AW  table index
- rom_data  in  32  entry; valid exactly 1 cycle after `rom_addr` changes
- di_term_addr  out  16  DI terminal address
- di_reg_addr  out  32  DI register address
- di_reg_datai  out  8  DI write data
- di_write_mode  out  1  DI write-mode level
- di_write  out  1  DI write strobe
- di_write_rdy  in  1  DI write ready
- di_transfer_status  in  16  DI status; 0 = ACK ok
- busy  out  1  sequence running
- done  out  1  1-cycle pulse at end of sequence (success or error)
- error  out  1  sticky error flag, cleared by `start`
- err_index  out  ROM_AW  entry index that failed

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0; retry count 0.
- Entry format:
  - [31:30] opcode: 00 WRITE, 01 DELAY, 10 END, 11 reserved.
  - WRITE: [23:8] reg_addr, [7:0] data.
  - DELAY: [23:0] cycle count N.
- `di_reg_addr` = {16'h0, reg_addr}. `di_term_addr` = `term_addr` latched at `start`.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACCEPT, WAIT_DONE, CHECK, GAP, DELAY, FINISH.
- IDLE:
  - `start` → clear `error`/`err_index`, index=0, `busy`=1 → FETCH.
  - `start` while `busy`=1 is ignored.
- FETCH: `rom_addr` = index; 1 cycle → DECODE.
- DECODE (samples `rom_data`):
  - WRITE → ISSUE, retry count 0.
  - DELAY → DELAY.
  - END → FINISH.
  - Reserved → `error`=1, `err_index`=index → FINISH.
- ISSUE: `di_write_mode`=1, `di_write`=1 for exactly this cycle → WAIT_ACCEPT.
- `di_write_mode` stays 1 from ISSUE through CHECK.
- WAIT_ACCEPT: `di_write_rdy`=0 → WAIT_DONE. Otherwise, after ACCEPT_WAIT cycles → CHECK; this covers an inactive terminal that holds ready high.
- WAIT_DONE: `di_write_rdy`=1 → CHECK. With no timeout, waits indefinitely.
- CHECK:
  - `di_transfer_status`==0 → GAP, then advance index.
  - Nonzero and retry count < MAX_RETRIES → retry count+1, GAP, then ISSUE the same entry.
  - Nonzero otherwise → `error`=1, `err_index`=index → GAP, then FINISH.
- GAP: `di_write_mode`=0 for GAP_CYCLES cycles; this lets downstream clear its status.
- Index advance: if index == 2**ROM_AW-1, treat as implicit END → FINISH. Otherwise index+1 → FETCH. No wrap to 0.
- DELAY:
  - Load counter with N and decrement once per cycle; at 0 advance index.
  - N=0 advances after 1 cycle.
  - The DI bus is idle during DELAY.
- FINISH: `done`=1 for 1 cycle, `busy`=0 → IDLE.
- Reset mid-operation: immediate return to IDLE. `di_write_mode`/`di_write` drop asynchronously; no `done` pulse.
- `start` coincident with reset: reset wins.

Optional Feature:
- Macro: DI_I2C_INIT_SEQ_TIMEOUT_EN.
- Defined: a 20-bit watchdog runs in WAIT_DONE. Reaching 20'hFFFFF counts as a failed attempt and follows the CHECK retry/error path. Also adds output `timeout` (1-bit, sticky, cleared by `start`).
- Undefined: no watchdog, no `timeout` port; WAIT_DONE waits indefinitely.

Decomposition:
- Shared package `di_i2c_pkg`:
  - opcode constants OP_WRITE/OP_DELAY/OP_END.
  - entry field bit positions.
  - status-OK constant 16'h0.
  - state encoding typedef.
- One sub-module: `di_i2c_init_delay` (loadable down-counter with zero flag), reused for the DELAY opcode and the GAP counter.

Test Plan:
- ROM {WRITE 0x0012/0xA5, WRITE 0x0013/0x5A, END}, downstream model always ACKs → two `di_write` pulses with addr 0x12/0x13, data A5/5A; `done` once; `error`=0; `busy` low after FINISH.
- Downstream NACKs entry 1 twice, then ACKs → 3 `di_write` pulses for entry 1, `di_write_mode` low ≥2 cycles between them; `error`=0.
- Entry 2 always NACKs, MAX_RETRIES=3 → 4 attempts, `error`=1, `err_index`=2, `done` pulses, entry 3 never issued.
- DELAY 100 between two writes → exactly 100+1 cycles with no DI activity between GAP end and the next ISSUE.
- Assert `reset` during WAIT_DONE → `di_write_mode`/`busy` 0 same cycle, no `done`; a fresh `start` restarts at index 0.
- Table with no END, ROM_AW=2 → 4 writes then `done`; `rom_addr` never wraps; `start` during `busy` ignored.
